// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STORE    = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam int unsigned ERR_DATA       = 0;
  localparam int unsigned ERR_END        = 1;
  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned CLR_CYCLES_DEF = 2;

  // FIFO entry layout: {enderror, errdata, rx_data[7:0]}
  localparam int unsigned ENTRY_W  = 10;
  localparam int unsigned FLAG_LSB = 8;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] data,
                                                    input logic       errdata,
                                                    input logic       enderror);
    logic [ENTRY_W-1:0] e;
    e                     = '0;
    e[7:0]                = data;
    e[FLAG_LSB+ERR_DATA]  = errdata;
    e[FLAG_LSB+ERR_END]   = enderror;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Signal bundle between uart_rx, the receive buffer and its consumer.
interface uart_rx_buffer_if #(
  parameter int unsigned DEPTH = uart_pkg::DEPTH_DEF
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ready;
  logic [7:0]    rx_data;
  logic          errdata;
  logic          enderror;
  logic          state_clear;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic [1:0]    rd_err;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          ovr_clr;
  logic [7:0]    err_cnt;

  modport slave (
    input  ready, rx_data, errdata, enderror, rd_en, ovr_clr,
    output state_clear, rd_data, rd_err, empty, full, count, overrun, err_cnt
  );

  modport master (
    output ready, rx_data, errdata, enderror, rd_en, ovr_clr,
    input  state_clear, rd_data, rd_err, empty, full, count, overrun, err_cnt
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; storage is not reset.
module sync_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_rd_en,
  output logic [DW-1:0]          o_rd_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_addr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;

  // A write into a full FIFO is only legal when the same edge frees a slot.
  assign w_pop  = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, keep presenting the most recently popped entry.
  assign w_rd_addr = o_empty ? (r_rptr - 1'b1) : r_rptr;
  assign o_rd_data = r_mem[w_rd_addr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures each uart_rx frame once, clears the receiver, and queues bytes with error flags.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_buffer_if.slave   bus
);

  localparam int unsigned       CW       = $clog2(DEPTH) + 1;
  localparam int unsigned       CCW      = $clog2(CLR_CYCLES + 1);
  localparam logic [CCW-1:0]    CLR_LAST = CCW'(CLR_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 w_capture;
  logic                 w_store;
  logic                 w_state_clear;
  logic [ENTRY_W-1:0]   r_hold;
  logic [CCW-1:0]       r_clr_cnt;
  logic                 r_overrun;
  logic [7:0]           r_err_cnt;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_empty;
  logic                 w_full;
  logic [CW-1:0]        w_count;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_hold_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_store       = 1'b0;
    w_state_clear = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.ready) begin
          w_capture = 1'b1;
          w_next    = STORE;
        end
      end
      STORE: begin
        w_store = 1'b1;
        w_next  = CLEAR;
      end
      CLEAR: begin
        w_state_clear = 1'b1;
        if (r_clr_cnt == CLR_LAST) w_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_pop      = bus.rd_en && !w_empty;
  assign w_drop     = w_store && w_full && !w_pop;
  assign w_hold_err = r_hold[FLAG_LSB+ERR_DATA] | r_hold[FLAG_LSB+ERR_END];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_clr_cnt <= '0;
      r_overrun <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_capture) r_hold <= pack_entry(bus.rx_data, bus.errdata, bus.enderror);
      r_clr_cnt <= (r_state == CLEAR) ? r_clr_cnt + 1'b1 : '0;
      if (w_drop)           r_overrun <= 1'b1;
      else if (bus.ovr_clr) r_overrun <= 1'b0;
      // Dropped frames still count toward the error total.
      if (w_store && w_hold_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_store),
    .i_wr_data (r_hold),
    .i_rd_en   (bus.rd_en),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  assign bus.state_clear = w_state_clear;
  assign bus.rd_data     = w_head[7:0];
  assign bus.rd_err      = w_head[FLAG_LSB+1:FLAG_LSB];
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.count       = w_count;
  assign bus.overrun     = r_overrun;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer against a queue-based reference model.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned CLR_CYCLES = 2;

  typedef struct {
    logic [7:0] d;
    logic [1:0] e;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_buffer_if #(.DEPTH(DEPTH)) u_if ();

  uart_rx_buffer #(
    .DEPTH      (DEPTH),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int     total = 0;
  int     bad   = 0;
  entry_t mq[$];
  bit     m_ovr;
  int     m_err;

  task automatic idle_inputs();
    u_if.ready    = 1'b0;
    u_if.rx_data  = '0;
    u_if.errdata  = 1'b0;
    u_if.enderror = 1'b0;
    u_if.rd_en    = 1'b0;
    u_if.ovr_clr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovr = 0;
    m_err = 0;
  endtask

  // strobe: 0 none, 1 rd_en during STORE, 2 ovr_clr during STORE
  task automatic send_frame(input logic [7:0] d, input logic ed, input logic ee,
                            input int strobe, input int hold);
    entry_t ent;
    int     n;
    bit     drop;
    @(negedge clk);
    u_if.ready    = 1'b1;
    u_if.rx_data  = d;
    u_if.errdata  = ed;
    u_if.enderror = ee;
    @(negedge clk);
    total++;
    if (u_if.state_clear !== 1'b0) begin
      bad++; $display("FAIL sc_in_store got=%b want=0", u_if.state_clear);
    end
    if (strobe == 1) begin
      if (mq.size() > 0) begin
        total++;
        if (u_if.rd_data !== mq[0].d || u_if.rd_err !== mq[0].e) begin
          bad++; $display("FAIL head_at_store got=%h/%b want=%h/%b",
                          u_if.rd_data, u_if.rd_err, mq[0].d, mq[0].e);
        end
      end
      u_if.rd_en = 1'b1;
    end else if (strobe == 2) begin
      u_if.ovr_clr = 1'b1;
    end
    @(negedge clk);
    u_if.rd_en   = 1'b0;
    u_if.ovr_clr = 1'b0;
    if (strobe == 1 && mq.size() > 0) void'(mq.pop_front());
    ent.d = d;
    ent.e = {ee, ed};
    drop = (mq.size() >= DEPTH);
    if (!drop) mq.push_back(ent);
    if (drop) m_ovr = 1;
    else if (strobe == 2) m_ovr = 0;
    if ((ed || ee) && m_err < 255) m_err++;
    total++;
    if (u_if.count !== mq.size()) begin
      bad++; $display("FAIL count_after_store got=%0d want=%0d", u_if.count, mq.size());
    end
    total++;
    if (u_if.empty !== (mq.size() == 0) || u_if.full !== (mq.size() == DEPTH)) begin
      bad++; $display("FAIL empty_full got=%b%b want=%b%b", u_if.empty, u_if.full,
                      mq.size() == 0, mq.size() == DEPTH);
    end
    total++;
    if (u_if.overrun !== m_ovr) begin
      bad++; $display("FAIL overrun got=%b want=%b", u_if.overrun, m_ovr);
    end
    total++;
    if (u_if.err_cnt !== 8'(m_err)) begin
      bad++; $display("FAIL err_cnt got=%0d want=%0d", u_if.err_cnt, m_err);
    end
    if (mq.size() > 0) begin
      total++;
      if (u_if.rd_data !== mq[0].d || u_if.rd_err !== mq[0].e) begin
        bad++; $display("FAIL head got=%h/%b want=%h/%b", u_if.rd_data, u_if.rd_err, mq[0].d, mq[0].e);
      end
    end
    n = 0;
    while (u_if.state_clear === 1'b1 && n < CLR_CYCLES + 4) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != CLR_CYCLES) begin
      bad++; $display("FAIL clear_len got=%0d want=%0d", n, CLR_CYCLES);
    end
    repeat (hold) @(negedge clk);
    total++;
    if (u_if.count !== mq.size() || u_if.state_clear !== 1'b0) begin
      bad++; $display("FAIL single_capture got=%0d/%b want=%0d/0", u_if.count, u_if.state_clear, mq.size());
    end
    u_if.ready = 1'b0;
  endtask

  task automatic pop_one();
    total++;
    if (u_if.empty !== 1'b0 || u_if.rd_data !== mq[0].d || u_if.rd_err !== mq[0].e) begin
      bad++; $display("FAIL pop_head got=%b/%h/%b want=0/%h/%b",
                      u_if.empty, u_if.rd_data, u_if.rd_err, mq[0].d, mq[0].e);
    end
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
    void'(mq.pop_front());
    total++;
    if (u_if.count !== mq.size()) begin
      bad++; $display("FAIL pop_count got=%0d want=%0d", u_if.count, mq.size());
    end
  endtask

  function automatic logic [7:0] par_tag(input int v);
    logic [6:0] d;
    d = 7'(v);
    return {^d, d};
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if (u_if.state_clear !== 1'b0 || u_if.count !== '0 || u_if.empty !== 1'b1 ||
        u_if.full !== 1'b0 || u_if.overrun !== 1'b0 || u_if.err_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_state got sc=%b cnt=%0d e=%b f=%b ovr=%b err=%0d want 0/0/1/0/0/0",
                      u_if.state_clear, u_if.count, u_if.empty, u_if.full, u_if.overrun, u_if.err_cnt);
    end
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
    total++;
    if (u_if.count !== '0 || u_if.empty !== 1'b1) begin
      bad++; $display("FAIL pop_when_empty got=%0d/%b want=0/1", u_if.count, u_if.empty);
    end
  endtask

  task automatic test_single();
    do_reset();
    send_frame(8'h81, 1'b0, 1'b0, 0, 0);
    pop_one();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 10; i++) send_frame(par_tag(i), 1'b0, 1'b0, 0, i % 3);
    while (mq.size() > 0) pop_one();
    total++;
    if (u_if.err_cnt !== 8'd0) begin
      bad++; $display("FAIL stream_err_cnt got=%0d want=0", u_if.err_cnt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_frame(8'h55, 1'b1, 1'b0, 0, 0);
    send_frame(8'h2A, 1'b0, 1'b1, 0, 0);
    total++;
    if (u_if.err_cnt !== 8'd2 || u_if.rd_err !== 2'b01) begin
      bad++; $display("FAIL errors got=%0d/%b want=2/01", u_if.err_cnt, u_if.rd_err);
    end
    while (mq.size() > 0) pop_one();
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 0, 0);
    total++;
    if (u_if.full !== 1'b1 || u_if.count !== 5'd16 || u_if.overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_state got=%b/%0d/%b want=1/16/1", u_if.full, u_if.count, u_if.overrun);
    end
    send_frame(8'hEE, 1'b0, 1'b0, 2, 0);
    @(negedge clk);
    u_if.ovr_clr = 1'b1;
    @(negedge clk);
    u_if.ovr_clr = 1'b0;
    m_ovr = 0;
    total++;
    if (u_if.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_clr got=%b want=0", u_if.overrun);
    end
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (u_if.rd_data !== 8'(i)) begin
        bad++; $display("FAIL retained got=%h want=%h", u_if.rd_data, 8'(i));
      end
      pop_one();
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 0, 0);
    send_frame(8'hA5, 1'b0, 1'b0, 1, 0);
    total++;
    if (u_if.count !== 5'd16 || u_if.overrun !== 1'b0 || u_if.rd_data !== 8'h41) begin
      bad++; $display("FAIL full_pop got=%0d/%b/%h want=16/0/41", u_if.count, u_if.overrun, u_if.rd_data);
    end
    while (mq.size() > 0) pop_one();
  endtask

  task automatic test_reset_mid();
    entry_t ent;
    int     n;
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    u_if.ready   = 1'b1;
    u_if.rx_data = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (u_if.state_clear !== 1'b1 || u_if.count !== 5'd4) begin
      bad++; $display("FAIL pre_reset got=%b/%0d want=1/4", u_if.state_clear, u_if.count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_ovr = 0; m_err = 0;
    total++;
    if (u_if.state_clear !== 1'b0 || u_if.empty !== 1'b1 || u_if.count !== '0) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%0d want=0/1/0", u_if.state_clear, u_if.empty, u_if.count);
    end
    @(negedge clk);
    @(negedge clk);
    ent.d = 8'h3C; ent.e = 2'b00;
    mq.push_back(ent);
    n = 0;
    while (u_if.state_clear === 1'b1 && n < CLR_CYCLES + 4) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    u_if.ready = 1'b0;
    total++;
    if (n != CLR_CYCLES || u_if.count !== 5'd1 || u_if.rd_data !== 8'h3C) begin
      bad++; $display("FAIL recapture got=%0d/%0d/%h want=%0d/1/3c", n, u_if.count, u_if.rd_data, CLR_CYCLES);
    end
    pop_one();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end else begin
        int k;
        k = int'($urandom_range(1, 4));
        while (k > 0 && mq.size() > 0) begin
          pop_one();
          k--;
        end
      end
    end
    while (mq.size() > 0) pop_one();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) send_frame(8'(i), 1'b1, i[0], 0, 0);
    total++;
    if (u_if.err_cnt !== 8'd255) begin
      bad++; $display("FAIL err_sat got=%0d want=255", u_if.err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_errors();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries; must be a power of two and at least 2.
REQ-002 Parameter CLR_CYCLES, default 2, number of cycles state_clear stays high per frame; must be at least 1.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ready  input  1  frame-received flag from uart_rx; held high until cleared.
REQ-006 rx_data  input  8  received byte from uart_rx; bit 7 is parity, bits 6:0 are data.
REQ-007 errdata  input  1  parity/data error flag from uart_rx; valid while ready=1.
REQ-008 enderror  input  1  frame (stop-bit) error flag from uart_rx; valid while ready=1.
REQ-009 state_clear  output  1  clears ready, errdata and enderror in uart_rx.
REQ-010 rd_en  input  1  consumer pop request.
REQ-011 rd_data  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-012 rd_err  output  2  head-of-FIFO flags: bit1 = enderror, bit0 = errdata.
REQ-013 empty  output  1  high when the FIFO holds 0 entries.
REQ-014 full  output  1  high when the FIFO holds DEPTH entries.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 overrun  output  1  sticky flag: a frame was dropped because the FIFO was full.
REQ-017 ovr_clr  input  1  clears overrun.
REQ-018 err_cnt  output  8  number of frames captured with any error flag set; saturating.

Function
REQ-019 Control FSM states SHALL be IDLE, STORE, CLEAR and WAIT_LOW.
- IDLE -> STORE when ready=1.
- STORE -> CLEAR unconditionally.
- CLEAR -> WAIT_LOW after CLR_CYCLES cycles.
- WAIT_LOW -> IDLE when ready=0.
REQ-020 On the IDLE->STORE edge, rx_data, errdata and enderror SHALL be latched into a holding register.
REQ-021 In STORE, the holding register SHALL be written to the FIFO when count<DEPTH, or when full and a pop occurs in the same cycle.
- When full with no pop in that cycle, the frame is dropped and overrun is set.
REQ-022 state_clear SHALL be high exactly while in CLEAR, i.e. CLR_CYCLES consecutive cycles, and low in all other states.
REQ-023 Each frame SHALL be stored at most once; ready remaining high after CLEAR SHALL NOT cause a second capture.
REQ-024 Latency: ready rising at edge N gives empty=0 and valid rd_data after edge N+2 when the FIFO was empty.
REQ-025 A pop SHALL occur on an edge with rd_en=1 and empty=0; rd_en while empty is ignored, with no underflow and no state change.
REQ-026 A simultaneous write and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 rd_data and rd_err SHALL reflect the entry at the read pointer combinationally from FIFO storage; they hold their last value when empty.
REQ-028 err_cnt SHALL increment by 1 per captured frame with errdata|enderror=1, including dropped frames, and saturate at 255.
REQ-029 When an overrun event and ovr_clr=1 occur in the same cycle, set SHALL win.

Reset
REQ-030 Synchronous reset SHALL force: FSM=IDLE, state_clear=0, count=0, empty=1, full=0, both pointers=0, overrun=0, err_cnt=0, holding register=0.
REQ-031 Reset asserted mid-frame, in any state, SHALL abandon the frame; a still-high ready after reset SHALL be captured as a new frame.
REQ-032 FIFO storage contents SHALL NOT require reset.

Structure
REQ-033 A shared package uart_pkg SHALL hold the FSM state encoding, the rd_err bit indices (ERR_DATA=0, ERR_END=1) and the DEPTH/CLR_CYCLES defaults.
REQ-034 FIFO storage and pointers SHALL live in one sub-module, sync_fifo (parameters DW=10, DEPTH); the FSM, counters and flags stay in uart_rx_buffer.

Verification
REQ-035 Single frame: ready=1 with rx_data=0x81 and no errors -> state_clear high for 2 cycles starting 2 edges later; empty=0, rd_data=0x81, rd_err=0, count=1.
REQ-036 Stream: the ten parity-tagged values for 1..10 sent through GenBuadRate/uart_tx/uart_rx -> ten entries popped in order, all rd_err=0, err_cnt=0.
REQ-037 Errors: frame 0x55 with errdata=1, then frame 0x2A with enderror=1 -> rd_err=01 then 10; err_cnt=2.
REQ-038 Overrun: 17 frames with no reads -> full=1, count=16, overrun=1, entries 1..16 retained; ovr_clr pulse -> overrun=0.
REQ-039 Full with simultaneous pop in STORE -> frame accepted, count stays 16, overrun stays 0.
REQ-040 Reset mid-operation: rst during CLEAR with 3 entries stored -> next cycle state_clear=0, empty=1, count=0; ready still high -> recaptured once.
